// File: rtl/rt_sba_obi_ctrl_pkg.sv
// Shared types and helpers for the system-bus-access (SBA) OBI master.
package rt_sba_obi_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } sba_state_e;

   typedef enum logic [2:0] {
      SbaOk      = 3'd0,
      SbaBadAddr = 3'd2,
      SbaAlign   = 3'd3,
      SbaSize    = 3'd4
   } sba_err_e;

   typedef enum logic [1:0] {
      Sba8  = 2'd0,
      Sba16 = 2'd1,
      Sba32 = 2'd2
   } sba_size_e;

   localparam int unsigned SbaDataWidth = 32;

   function automatic logic sba_misaligned(sba_size_e size, logic [1:0] off);
      logic bad;
      bad = 1'b0;
      case (size)
         Sba16:   bad = off[0];
         Sba32:   bad = |off;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] sba_size_bytes(sba_size_e size);
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/rt_sba_obi_ctrl_if.sv
// OBI request/response channel between the SBA engine and the crossbar.
interface rt_sba_obi_ctrl_if #(
   parameter int unsigned AW = 32
);
   logic          req;
   logic          gnt;
   logic [AW-1:0] addr;
   logic          we;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          rvalid;
   logic [31:0]   rdata;
   logic          err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/rt_sba_obi_ctrl_lane.sv
// Byte-lane steering: byte enables and write replication on launch,
// right-aligned zero-extended extraction of read data on response.
module rt_sba_lane
   import rt_sba_obi_ctrl_pkg::*;
(
   input  sba_size_e   tx_size_i,
   input  logic [1:0]  tx_off_i,
   input  logic [31:0] tx_wdata_i,
   output logic [3:0]  tx_be_o,
   output logic [31:0] tx_wdata_o,
   input  sba_size_e   rx_size_i,
   input  logic [1:0]  rx_off_i,
   input  logic [31:0] rx_rdata_i,
   output logic [31:0] rx_rdata_o
);

   logic [31:0] rx_shifted;

   always_comb begin
      tx_be_o    = '0;
      tx_wdata_o = '0;
      case (tx_size_i)
         Sba8: begin
            tx_be_o    = 4'b0001 << tx_off_i;
            tx_wdata_o = {4{tx_wdata_i[7:0]}};
         end
         Sba16: begin
            tx_be_o    = 4'b0011 << tx_off_i;
            tx_wdata_o = {2{tx_wdata_i[15:0]}};
         end
         default: begin
            tx_be_o    = 4'b1111 << tx_off_i;
            tx_wdata_o = tx_wdata_i;
         end
      endcase
   end

   always_comb begin
      rx_shifted = rx_rdata_i >> {rx_off_i, 3'b000};
      rx_rdata_o = '0;
      case (rx_size_i)
         Sba8:    rx_rdata_o = rx_shifted & 32'h0000_00FF;
         Sba16:   rx_rdata_o = rx_shifted & 32'h0000_FFFF;
         default: rx_rdata_o = rx_shifted;
      endcase
   end

endmodule

// File: rtl/rt_sba_obi_ctrl.sv
// SBA engine: turns SBAddress0/SBData0 accesses into single OBI transactions,
// tracking sbbusy, sberror and sbbusyerror for the debug module.
module rt_sba_obi_ctrl
   import rt_sba_obi_ctrl_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned MaxAccess = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 addr_we_i,
   input  logic                 data_we_i,
   input  logic                 data_re_i,
   input  logic [31:0]          wdata_i,
   input  logic                 cfg_readonaddr_i,
   input  logic                 cfg_readondata_i,
   input  logic                 cfg_autoinc_i,
   input  logic [2:0]           cfg_access_i,
   input  logic                 sberr_clr_i,
   input  logic                 busyerr_clr_i,
   output logic [AddrWidth-1:0] address_o,
   output logic [31:0]          rdata_o,
   output logic                 busy_o,
   output logic [2:0]           sberror_o,
   output logic                 sbbusyerror_o,
   rt_sba_obi_ctrl_if.master    obi
);

   sba_state_e           state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [31:0]          rdata_q;
   sba_err_e             sberror_q;
   logic                 busyerr_q;
   logic                 req_q;
   logic [AddrWidth-1:0] obi_addr_q;
   logic                 obi_we_q;
   logic [3:0]           obi_be_q;
   logic [31:0]          obi_wdata_q;
   sba_size_e            size_q;

   logic                 idle;
   logic                 strobe_any;
   logic                 wr_trig;
   logic                 rd_trig;
   logic                 gated;
   logic                 size_bad;
   logic                 misalign;
   sba_size_e            tx_size;
   logic [AddrWidth-1:0] launch_addr;
   logic [3:0]           tx_be;
   logic [31:0]          tx_wdata;
   logic [31:0]          rx_rdata;

   // A simultaneous address write feeds the launch address directly, so a
   // write strobed together with it targets the new address.
   always_comb begin
      idle        = (state_q == IDLE);
      strobe_any  = addr_we_i | data_we_i | data_re_i;
      wr_trig     = data_we_i;
      rd_trig     = ~data_we_i & ((addr_we_i & cfg_readonaddr_i) |
                                  (data_re_i & cfg_readondata_i));
      gated       = (sberror_q != SbaOk) | busyerr_q;
      size_bad    = cfg_access_i > 3'(MaxAccess);
      tx_size     = size_bad ? Sba8 : sba_size_e'(cfg_access_i[1:0]);
      launch_addr = addr_we_i ? AddrWidth'(wdata_i) : addr_q;
      misalign    = sba_misaligned(tx_size, launch_addr[1:0]);
   end

   rt_sba_lane u_lane (
      .tx_size_i  (tx_size),
      .tx_off_i   (launch_addr[1:0]),
      .tx_wdata_i (wdata_i),
      .tx_be_o    (tx_be),
      .tx_wdata_o (tx_wdata),
      .rx_size_i  (size_q),
      .rx_off_i   (obi_addr_q[1:0]),
      .rx_rdata_i (obi.rdata),
      .rx_rdata_o (rx_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rdata_q     <= '0;
         sberror_q   <= SbaOk;
         busyerr_q   <= 1'b0;
         req_q       <= 1'b0;
         obi_addr_q  <= '0;
         obi_we_q    <= 1'b0;
         obi_be_q    <= '0;
         obi_wdata_q <= '0;
         size_q      <= Sba8;
      end else begin
         // Clears first; any set later in this block overrides them.
         if (sberr_clr_i)   sberror_q <= SbaOk;
         if (busyerr_clr_i) busyerr_q <= 1'b0;
         if (!idle && strobe_any) busyerr_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (addr_we_i) addr_q <= AddrWidth'(wdata_i);
               if ((wr_trig || rd_trig) && !gated) begin
                  if (size_bad) begin
                     sberror_q <= SbaSize;
                  end else if (misalign) begin
                     sberror_q <= SbaAlign;
                  end else begin
                     state_q     <= REQ;
                     req_q       <= 1'b1;
                     obi_addr_q  <= launch_addr;
                     obi_we_q    <= wr_trig;
                     obi_be_q    <= tx_be;
                     obi_wdata_q <= wr_trig ? tx_wdata : '0;
                     size_q      <= tx_size;
                  end
               end
            end
            REQ: begin
               if (obi.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= RSP;
               end
            end
            RSP: begin
               if (obi.rvalid) begin
                  state_q <= IDLE;
                  if (obi.err) begin
                     sberror_q <= SbaBadAddr;
                  end else begin
                     if (!obi_we_q) rdata_q <= rx_rdata;
                     if (cfg_autoinc_i) addr_q <= addr_q + AddrWidth'(sba_size_bytes(size_q));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign address_o     = addr_q;
   assign rdata_o       = rdata_q;
   assign busy_o        = (state_q != IDLE);
   assign sberror_o     = sberror_q;
   assign sbbusyerror_o = busyerr_q;

   assign obi.req   = req_q;
   assign obi.addr  = obi_addr_q;
   assign obi.we    = obi_we_q;
   assign obi.be    = obi_be_q;
   assign obi.wdata = obi_wdata_q;

endmodule

// File: tb/tb_rt_sba_obi_ctrl.sv
// Self-checking bench for rt_sba_obi_ctrl: vector table plus corner-case sequences,
// with an OBI slave model and a transaction scoreboard.
module tb_rt_sba_obi_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        addr_we = 1'b0, data_we = 1'b0, data_re = 1'b0;
   logic [31:0] wdata = '0;
   logic        readonaddr = 1'b0, readondata = 1'b0, autoinc = 1'b0;
   logic [2:0]  access = 3'd2;
   logic        sberr_clr = 1'b0, busyerr_clr = 1'b0;
   logic [31:0] address, rdata;
   logic        busy, sbbusyerror;
   logic [2:0]  sberror;

   rt_sba_obi_ctrl_if bus ();

   rt_sba_obi_ctrl #(.AddrWidth(32), .MaxAccess(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .addr_we_i        (addr_we),
      .data_we_i        (data_we),
      .data_re_i        (data_re),
      .wdata_i          (wdata),
      .cfg_readonaddr_i (readonaddr),
      .cfg_readondata_i (readondata),
      .cfg_autoinc_i    (autoinc),
      .cfg_access_i     (access),
      .sberr_clr_i      (sberr_clr),
      .busyerr_clr_i    (busyerr_clr),
      .address_o        (address),
      .rdata_o          (rdata),
      .busy_o           (busy),
      .sberror_o        (sberror),
      .sbbusyerror_o    (sbbusyerror),
      .obi              (bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // OBI slave model: grant after gnt_delay cycles of req, respond next cycle.
   logic [31:0] mem [logic [29:0]];
   int          gnt_delay = 0;
   int          wcnt;
   logic        inject_err = 1'b0;
   logic        stray_rv = 1'b0;
   logic        rv_q, rerr_q;
   logic [31:0] rd_q;

   assign bus.gnt    = bus.req && (wcnt >= gnt_delay);
   assign bus.rvalid = rv_q | stray_rv;
   assign bus.err    = rerr_q;
   assign bus.rdata  = stray_rv ? 32'h5A5A_5A5A : rd_q;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt   <= 0;
         rv_q   <= 1'b0;
         rerr_q <= 1'b0;
         rd_q   <= '0;
      end else begin
         rv_q   <= 1'b0;
         rerr_q <= 1'b0;
         if (bus.req && !bus.gnt) wcnt <= wcnt + 1;
         if (bus.req && bus.gnt) begin
            wcnt   <= 0;
            rv_q   <= 1'b1;
            rerr_q <= inject_err;
            rd_q   <= mem.exists(bus.addr[31:2]) ? mem[bus.addr[31:2]] : 32'h0;
         end
      end
   end

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } txn_t;

   txn_t exp_q[$];

   // Scoreboard: compare each granted transaction against the queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.req && bus.gnt) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_unexpected: got txn addr=0x%08h we=%0d, expected none",
                        bus.addr, bus.we);
            end else begin
               txn_t e;
               e = exp_q.pop_front();
               chk("sb_addr", bus.addr, e.addr);
               chk("sb_we", 32'(bus.we), 32'(e.we));
               chk("sb_be", 32'(bus.be), 32'(e.be));
               if (e.we) chk("sb_wdata", bus.wdata, e.wdata);
            end
         end
      end
   end

   task automatic strobe(input logic aw, input logic dw, input logic dr, input logic [31:0] d,
                         input logic sclr = 1'b0, input logic bclr = 1'b0);
      addr_we = aw; data_we = dw; data_re = dr; wdata = d;
      sberr_clr = sclr; busyerr_clr = bclr;
      @(posedge clk); #1;
      addr_we = 1'b0; data_we = 1'b0; data_re = 1'b0;
      sberr_clr = 1'b0; busyerr_clr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 50; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        rd;
      logic [2:0]  acc;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] memw;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rdata;
      logic [2:0]  exp_err;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b0, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         4'hF, 32'hDEAD_BEEF, 32'h0,         3'd0};
      vecs[1]  = '{1'b1, 3'd0, 32'h0000_1003, 32'h0,         32'hAABB_CCDD, 4'h8, 32'h0,         32'h0000_00AA, 3'd0};
      vecs[2]  = '{1'b1, 3'd0, 32'h0000_1001, 32'h0,         32'hAABB_CCDD, 4'h2, 32'h0,         32'h0000_00CC, 3'd0};
      vecs[3]  = '{1'b1, 3'd1, 32'h0000_1002, 32'h0,         32'hAABB_CCDD, 4'hC, 32'h0,         32'h0000_AABB, 3'd0};
      vecs[4]  = '{1'b1, 3'd2, 32'h0000_2000, 32'h0,         32'h1122_3344, 4'hF, 32'h0,         32'h1122_3344, 3'd0};
      vecs[5]  = '{1'b0, 3'd0, 32'h0000_1002, 32'h1234_5678, 32'h0,         4'h4, 32'h7878_7878, 32'h0,         3'd0};
      vecs[6]  = '{1'b0, 3'd1, 32'h0000_1006, 32'h0000_CAFE, 32'h0,         4'hC, 32'hCAFE_CAFE, 32'h0,         3'd0};
      vecs[7]  = '{1'b1, 3'd1, 32'h0000_1001, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         3'd3};
      vecs[8]  = '{1'b0, 3'd2, 32'h0000_1002, 32'h5555_5555, 32'h0,         4'h0, 32'h0,         32'h0,         3'd3};
      vecs[9]  = '{1'b1, 3'd3, 32'h0000_1000, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         3'd4};
      vecs[10] = '{1'b0, 3'd7, 32'h0000_1000, 32'h6666_6666, 32'h0,         4'h0, 32'h0,         32'h0,         3'd4};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_address", address, 32'h0);
      chk("rst_sberror", 32'(sberror), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 32b write timing with same-cycle grant
      access = 3'd2;
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_1000);
      exp_q.push_back('{32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF});
      strobe(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      chk("t_req_rise", 32'(bus.req), 32'd1);
      chk("t_busy1", 32'(busy), 32'd1);
      chk("t_be", 32'(bus.be), 32'hF);
      @(posedge clk); #1;
      chk("t_busy2", 32'(busy), 32'd1);
      chk("t_req_fall", 32'(bus.req), 32'd0);
      @(posedge clk); #1;
      chk("t_busy_done", 32'(busy), 32'd0);

      // Vector table
      foreach (vecs[i]) begin
         access = vecs[i].acc;
         readonaddr = 1'b0;
         if (vecs[i].rd) mem[vecs[i].addr[31:2]] = vecs[i].memw;
         if (vecs[i].exp_err == 3'd0)
            exp_q.push_back('{vecs[i].addr, !vecs[i].rd, vecs[i].exp_be, vecs[i].exp_wd});
         if (vecs[i].rd) begin
            readonaddr = 1'b1;
            strobe(1'b1, 1'b0, 1'b0, vecs[i].addr);
         end else begin
            strobe(1'b1, 1'b0, 1'b0, vecs[i].addr);
            strobe(1'b0, 1'b1, 1'b0, vecs[i].wd);
         end
         wait_idle($sformatf("v%0d_idle", i));
         chk($sformatf("v%0d_sberror", i), 32'(sberror), 32'(vecs[i].exp_err));
         if (vecs[i].rd && vecs[i].exp_err == 3'd0)
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         if (vecs[i].exp_err != 3'd0) begin
            strobe(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("v%0d_clr", i), 32'(sberror), 32'd0);
         end
      end
      readonaddr = 1'b0;

      // Auto-increment with read-on-data
      access = 3'd2; autoinc = 1'b1; readondata = 1'b1;
      mem[30'h800] = 32'h0101_0101;
      mem[30'h801] = 32'h0202_0202;
      mem[30'h802] = 32'h0303_0303;
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_2000);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back('{32'h0000_2000 + 32'(4 * k), 1'b0, 4'hF, 32'h0});
         strobe(1'b0, 1'b0, 1'b1, 32'h0);
         wait_idle("ai_idle");
      end
      chk("ai_address", address, 32'h0000_200C);
      chk("ai_rdata", rdata, 32'h0303_0303);
      readondata = 1'b0; autoinc = 1'b0;

      // Access while busy; set and clear together leaves the flag set
      gnt_delay = 5;
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_3000);
      exp_q.push_back('{32'h0000_3000, 1'b1, 4'hF, 32'h1111_1111});
      strobe(1'b0, 1'b1, 1'b0, 32'h1111_1111);
      strobe(1'b1, 1'b1, 1'b0, 32'h0000_9999, 1'b0, 1'b1);
      chk("be_set_wins", 32'(sbbusyerror), 32'd1);
      wait_idle("be_idle");
      chk("be_addr_kept", address, 32'h0000_3000);
      strobe(1'b0, 1'b1, 1'b0, 32'h3333_3333);
      chk("be_blocked", 32'(busy), 32'd0);
      chk("be_still_set", 32'(sbbusyerror), 32'd1);
      strobe(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("be_cleared", 32'(sbbusyerror), 32'd0);
      exp_q.push_back('{32'h0000_3000, 1'b1, 4'hF, 32'h4444_4444});
      strobe(1'b0, 1'b1, 1'b0, 32'h4444_4444);
      chk("be_relaunch", 32'(busy), 32'd1);
      wait_idle("be_idle2");
      gnt_delay = 0;

      // OBI error response: sberror=2, rdata held, no increment, then gating
      autoinc = 1'b1; readonaddr = 1'b1;
      mem[30'h1400] = 32'h0BAD_F00D;
      exp_q.push_back('{32'h0000_5000, 1'b0, 4'hF, 32'h0});
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_5000);
      wait_idle("oe_idle1");
      chk("oe_rdata_ok", rdata, 32'h0BAD_F00D);
      chk("oe_inc_ok", address, 32'h0000_5004);
      mem[30'h1000] = 32'hFFFF_FFFF;
      inject_err = 1'b1;
      exp_q.push_back('{32'h0000_4000, 1'b0, 4'hF, 32'h0});
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_4000);
      wait_idle("oe_idle2");
      inject_err = 1'b0;
      chk("oe_sberror", 32'(sberror), 32'd2);
      chk("oe_rdata_held", rdata, 32'h0BAD_F00D);
      chk("oe_no_inc", address, 32'h0000_4000);
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_4100);
      chk("oe_gated", 32'(busy), 32'd0);
      chk("oe_addr_upd", address, 32'h0000_4100);
      strobe(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("oe_clr", 32'(sberror), 32'd0);
      readonaddr = 1'b0;

      // Address wrap on auto-increment
      strobe(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
      exp_q.push_back('{32'hFFFF_FFFC, 1'b1, 4'hF, 32'hA5A5_A5A5});
      strobe(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
      wait_idle("wrap_idle");
      chk("wrap_address", address, 32'h0);
      autoinc = 1'b0;

      // Asynchronous reset while in REQ, then a stray rvalid
      gnt_delay = 20;
      strobe(1'b1, 1'b0, 1'b0, 32'h0000_6000);
      strobe(1'b0, 1'b1, 1'b0, 32'h7777_7777);
      chk("ar_req_up", 32'(bus.req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req_drop", 32'(bus.req), 32'd0);
      chk("ar_busy_drop", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      gnt_delay = 0;
      @(posedge clk); #1;
      chk("ar_address", address, 32'h0);
      chk("ar_be", 32'(bus.be), 32'd0);
      chk("ar_obi_addr", bus.addr, 32'h0);
      stray_rv = 1'b1;
      @(posedge clk); #1;
      stray_rv = 1'b0;
      @(posedge clk); #1;
      chk("ar_stray_busy", 32'(busy), 32'd0);
      chk("ar_stray_rdata", rdata, 32'h0);
      chk("ar_stray_err", 32'(sberror), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
